// File: rtl/spi_frame_tx.sv
// SPI mode-0 slave that streams one framebuffer frame per chip-select window:
// a header word followed by FRAME_WORDS words read from the selected buffer, MSB first.
module spi_frame_tx #(
    parameter int unsigned          WORD_BITS   = 16,
    parameter int unsigned          FRAME_WORDS = 4800,
    parameter int unsigned          ADDR_WIDTH  = 13,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [WORD_BITS-1:0] HEADER_WORD = 16'hA55A
) (
    input  logic                  cam_pclk,
    input  logic                  rst,
    input  logic                  frame_ready,
    input  logic                  buf_sel,
    output logic                  frame_busy,
    output logic                  rd_buf,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [WORD_BITS-1:0]  rd_data,
    input  logic                  spi_sck,
    input  logic                  spi_ncs,
    output logic                  spi_miso,
    output logic [7:0]            frame_count,
    output logic [7:0]            drop_count
);
    localparam int unsigned BitW  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned WordW = $clog2(FRAME_WORDS + 1);

    localparam logic [BitW-1:0]       LastBit  = BitW'(WORD_BITS - 1);
    localparam logic [WordW-1:0]      LastWord = WordW'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StXfer, StDone} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, ncs_sync_q;
    logic                   sck_prev_q, ncs_prev_q;
    logic                   rd_buf_q, rd_buf_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [WORD_BITS-1:0]   pf_q, pf_d;
    logic                   fetch_wait_q, fetch_wait_d;
    logic                   fetch_cap_q, fetch_cap_d;
    logic                   fetch_done_q, fetch_done_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [WordW-1:0]       word_q, word_d;
    logic [7:0]             frame_count_q, frame_count_d;
    logic [7:0]             drop_count_q, drop_count_d;

    logic sck_s, ncs_s, sck_fall, ncs_fall, ncs_rise;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ncs_s    = ncs_sync_q[SYNC_STAGES-1];
    assign sck_fall = sck_prev_q & ~sck_s;
    assign ncs_fall = ncs_prev_q & ~ncs_s;
    assign ncs_rise = ~ncs_prev_q & ncs_s;

    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            sck_sync_q    <= '0;
            ncs_sync_q    <= '0;
            sck_prev_q    <= 1'b0;
            ncs_prev_q    <= 1'b0;
            rd_buf_q      <= 1'b0;
            rd_addr_q     <= '0;
            shift_q       <= '0;
            pf_q          <= '0;
            fetch_wait_q  <= 1'b0;
            fetch_cap_q   <= 1'b0;
            fetch_done_q  <= 1'b0;
            bit_q         <= '0;
            word_q        <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            ncs_sync_q    <= {ncs_sync_q[SYNC_STAGES-2:0], spi_ncs};
            sck_prev_q    <= sck_s;
            ncs_prev_q    <= ncs_s;
            rd_buf_q      <= rd_buf_d;
            rd_addr_q     <= rd_addr_d;
            shift_q       <= shift_d;
            pf_q          <= pf_d;
            fetch_wait_q  <= fetch_wait_d;
            fetch_cap_q   <= fetch_cap_d;
            fetch_done_q  <= fetch_done_d;
            bit_q         <= bit_d;
            word_q        <= word_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rd_buf_d      = rd_buf_q;
        rd_addr_d     = rd_addr_q;
        shift_d       = shift_q;
        pf_d          = pf_q;
        fetch_wait_d  = 1'b0;
        fetch_cap_d   = 1'b0;
        fetch_done_d  = fetch_done_q;
        bit_d         = bit_q;
        word_d        = word_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;

        if (frame_ready && (state_q != StIdle) && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end

        // Read pipeline: address held one cycle, data captured the cycle after.
        if (state_q == StXfer) begin
            fetch_cap_d = fetch_wait_q;
            if (fetch_cap_q) begin
                pf_d = rd_data;
                if (rd_addr_q != LastAddr) begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end else begin
                    fetch_done_d = 1'b1;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (frame_ready) begin
                    rd_buf_d = buf_sel;
                    state_d  = StArmed;
                end
            end
            StArmed: begin
                if (ncs_fall) begin
                    shift_d      = HEADER_WORD;
                    rd_addr_d    = '0;
                    bit_d        = '0;
                    word_d       = '0;
                    fetch_wait_d = 1'b1;
                    fetch_cap_d  = 1'b0;
                    fetch_done_d = 1'b0;
                    state_d      = StXfer;
                end
            end
            StXfer: begin
                if (ncs_rise) begin
                    fetch_cap_d = 1'b0;
                    state_d     = StArmed;
                end else if (sck_fall && !ncs_s) begin
                    if (bit_q == LastBit) begin
                        if (word_q == LastWord) begin
                            state_d = StDone;
                        end else begin
                            shift_d      = pf_q;
                            bit_d        = '0;
                            word_d       = word_q + WordW'(1);
                            fetch_wait_d = ~fetch_done_q;
                        end
                    end else begin
                        shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
                        bit_d   = bit_q + BitW'(1);
                    end
                end
            end
            StDone: begin
                if (ncs_rise) begin
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign frame_busy  = (state_q != StIdle);
    assign rd_buf      = rd_buf_q;
    assign rd_addr     = rd_addr_q;
    assign spi_miso    = (state_q == StXfer) & shift_q[WORD_BITS-1];
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: doc/spi_frame_tx.md
SPI_FRAME_TX -- requirements
Module: spi_frame_tx

Interface
REQ-001 SHALL have parameter WORD_BITS, default 16, meaning framebuffer word width and SPI word length.
REQ-002 SHALL have parameter FRAME_WORDS, default 4800, meaning data words per frame.
REQ-003 SHALL have parameter ADDR_WIDTH, default 13, meaning framebuffer read-address width, with 2**ADDR_WIDTH >= FRAME_WORDS.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on spi_sck and spi_ncs, minimum 2.
REQ-005 SHALL have parameter HEADER_WORD, default 16'hA55A, width WORD_BITS, meaning the word sent before the frame data.
REQ-006 SHALL have port cam_pclk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port frame_ready, input, 1 bit: one-cycle pulse indicating a complete frame is in a buffer.
REQ-009 SHALL have port buf_sel, input, 1 bit: buffer holding that frame; valid with frame_ready.
REQ-010 SHALL have port frame_busy, output, 1 bit: high from frame latch until transfer end or abort.
REQ-011 SHALL have port rd_buf, output, 1 bit: latched buffer select for the reads.
REQ-012 SHALL have port rd_addr, output, ADDR_WIDTH bits: framebuffer word address.
REQ-013 SHALL have port rd_data, input, WORD_BITS bits: framebuffer data, valid exactly 1 cycle after rd_addr.
REQ-014 SHALL have port spi_sck, input, 1 bit: SPI clock, mode 0, asynchronous.
REQ-015 SHALL have port spi_ncs, input, 1 bit: chip select, active low, asynchronous.
REQ-016 SHALL have port spi_miso, output, 1 bit: serial data out, MSB first.
REQ-017 SHALL have port frame_count, output, 8 bits: completed frames, wraps modulo 256.
REQ-018 SHALL have port drop_count, output, 8 bits: frame_ready pulses ignored while not IDLE; saturates at 255.

Function
REQ-019 SHALL pass spi_sck and spi_ncs through SYNC_STAGES flops, and SHALL detect edges on the synchronized versions only.
REQ-020 SHALL support SCK high and low phases each >= SYNC_STAGES+3 cam_pclk cycles; faster SCK is out of scope.
REQ-021 SHALL implement states IDLE, ARMED, XFER and DONE.
REQ-022 In IDLE, on frame_ready, SHALL latch buf_sel into rd_buf, set frame_busy, and enter ARMED the next cycle.
REQ-023 In ARMED, on synchronized ncs fall, SHALL load the shift register with HEADER_WORD, set rd_addr=0, clear word and bit counters, and enter XFER.
REQ-024 In XFER, spi_miso SHALL equal the shift-register MSB, and each synchronized SCK fall SHALL shift left by one.
REQ-025 On the WORD_BITS-th fall of a word, SHALL load the prefetched next word instead of shifting.
REQ-026 SHALL capture rd_data one cycle after each rd_addr change into a prefetch register, then increment rd_addr; rd_addr SHALL NOT exceed FRAME_WORDS-1.
REQ-027 SHALL send a total of 1+FRAME_WORDS words; after the last bit of data word FRAME_WORDS-1 is shifted out, SHALL enter DONE.
REQ-028 In DONE, on synchronized ncs rise, SHALL increment frame_count, clear frame_busy, and enter IDLE.
REQ-029 Synchronized ncs rise in ARMED or XFER SHALL abort: return to ARMED with the same rd_buf, frame_busy held, counters unchanged.
REQ-030 spi_miso SHALL be 0 whenever the state is not XFER.
REQ-031 frame_ready in any state other than IDLE SHALL increment drop_count, saturating at 255, and SHALL NOT change rd_buf.
REQ-032 Extra SCK edges in DONE SHALL be ignored.
REQ-033 SCK edges coincident with ncs high (synchronized) SHALL be ignored.

Reset
REQ-034 On rst, all of the following SHALL hold asynchronously: state=IDLE, frame_busy=0, rd_buf=0, rd_addr=0, spi_miso=0, frame_count=0, drop_count=0, shift/prefetch/sync registers=0.
REQ-035 rst mid-transfer SHALL discard the frame with no counter update; after release, SHALL wait for a new frame_ready.

Verification (WORD_BITS=16, FRAME_WORDS=4, SYNC_STAGES=2, SCK half-period 8 cycles)
REQ-036 Sequence frame_ready with buf_sel=1, ncs low, 80 SCK clocks, ncs high, memory words 0x1234, 0x5678, 0x9ABC, 0xDEF0 -> MISO stream A55A 1234 5678 9ABC DEF0, rd_buf=1, frame_count=1, frame_busy=0.
REQ-037 Sequence frame_ready, then ncs up after 20 SCK clocks, then a full 80-clock read -> the full read restarts at A55A, frame_count=1.
REQ-038 Three frame_ready pulses during a transfer -> drop_count=3, rd_buf unchanged; 300 such pulses -> drop_count=255.
REQ-039 rst asserted at SCK clock 40 -> all outputs 0 immediately; a new ncs low without frame_ready -> MISO stays 0.
REQ-040 Check rd_addr sequence across one frame -> 0,1,2,3 in order, never 4, each held >= 1 cycle before capture.
